// File: rtl/mem_channel_if.sv
// Controller-to-memory channel: one ready/valid request path and a
// one-cycle response pulse with data.
interface mem_channel_if #(
    parameter int DATA_WIDTH           = 32,
    parameter int ADDR_WIDTH           = 8,
    parameter int CACHE_LINE_BYTE_SIZE = 4
);
    logic                            mem_ready;
    logic                            mem_valid;
    logic [CACHE_LINE_BYTE_SIZE-1:0] mem_we;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]           mem_data;
    logic                            mem_resp_valid;
    logic [DATA_WIDTH-1:0]           mem_resp_data;

    modport master (
        input  mem_ready, mem_resp_valid, mem_resp_data,
        output mem_valid, mem_we, mem_addr, mem_data
    );

    modport slave (
        output mem_ready, mem_resp_valid, mem_resp_data,
        input  mem_valid, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/mem_channel.sv
// Behavioural single-channel memory responder with fixed response latency.
// Optional ready stalling driven by an LFSR when MEM_CHANNEL_STALL_EN is defined.
//
// state | meaning
// IDLE  | ready for a request (unless stalled)
// BUSY  | request accepted, latency counter running
// RESP  | one-cycle response pulse on mem_resp_valid
module mem_channel #(
    parameter int DATA_WIDTH           = 32,
    parameter int ADDR_WIDTH           = 8,
    parameter int CACHE_LINE_BYTE_SIZE = 4,
    parameter int DEPTH                = 256,
    parameter int LATENCY              = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_channel_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [DATA_WIDTH-1:0] mem_array [DEPTH];
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [IDX_W-1:0]      idx;
    logic                  stall_ok;
    logic                  ready;
    logic                  accept;

    assign idx = bus.mem_addr[IDX_W-1:0];

`ifdef MEM_CHANNEL_STALL_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign stall_ok = (lfsr[1:0] != 2'b00);
`else
    assign stall_ok = 1'b1;
`endif

    assign ready  = (state == IDLE) && stall_ok;
    assign accept = bus.mem_valid && ready && !reset;

    // Post-write word; with an all-zero mask this is just the stored word.
    always_comb begin
        merged = mem_array[idx];
        for (int i = 0; i < CACHE_LINE_BYTE_SIZE; i++) begin
            if (bus.mem_we[i]) begin
                merged[i*8 +: 8] = bus.mem_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? RESP : BUSY;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                cnt_next = cnt - 1'b1;
                // counter reaches zero on the same edge that enters RESP
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_array[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q    <= '0;
            resp_data <= '0;
        end else begin
            if (accept) begin
                word_q <= merged;
            end
            if (state_next == RESP) begin
                resp_data <= (state == IDLE) ? merged : word_q;
            end
        end
    end

    assign bus.mem_ready      = ready;
    assign bus.mem_resp_valid = (state == RESP);
    assign bus.mem_resp_data  = resp_data;
endmodule

// File: tb/tb_mem_channel.sv
// Directed bench for mem_channel: a LATENCY=4/DEPTH=256 instance and a
// LATENCY=1/DEPTH=16 instance, responses checked against a scoreboard.
module tb_mem_channel;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t q0[$];
    exp_t q1[$];

    mem_channel_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CACHE_LINE_BYTE_SIZE(4)) if0 ();
    mem_channel_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CACHE_LINE_BYTE_SIZE(4)) if1 ();

    mem_channel #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CACHE_LINE_BYTE_SIZE(4),
                  .DEPTH(256), .LATENCY(4)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    mem_channel #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CACHE_LINE_BYTE_SIZE(4),
                  .DEPTH(16), .LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response scoreboards: data and arrival cycle of every pulse.
    always @(negedge clk) begin
        if (if0.mem_resp_valid === 1'b1) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0_resp_data", if0.mem_resp_data, e.data);
                check("dut0_resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (if1.mem_resp_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_resp_data", if1.mem_resp_data, e.data);
                check("dut1_resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge with
    // mem_valid still asserted. acc is the cycle of the accept edge (cycle 0).
    task automatic req(input int sel, input logic [7:0] addr, input logic [3:0] we,
                       input logic [31:0] data, input logic [31:0] exp, output int acc);
        logic rdy;
        exp_t e;
        acc = -1;
        if (sel == 0) begin
            if0.mem_valid = 1'b1; if0.mem_addr = addr; if0.mem_we = we; if0.mem_data = data;
        end else begin
            if1.mem_valid = 1'b1; if1.mem_addr = addr; if1.mem_we = we; if1.mem_data = data;
        end
        for (int k = 0; k < 50; k++) begin
            rdy = (sel == 0) ? if0.mem_ready : if1.mem_ready;
            if (rdy === 1'b1) begin
                acc    = cyc;
                e.data = exp;
                e.cyc  = cyc + ((sel == 0) ? 4 : 1);
                if (sel == 0) q0.push_back(e); else q1.push_back(e);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_all();
        if0.mem_valid = 1'b0;
        if1.mem_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    int acc, acc2;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed cycle %0d required finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0;
        reset = 1'b1;
        if0.mem_valid = 1'b0; if0.mem_we = '0; if0.mem_addr = '0; if0.mem_data = '0;
        if1.mem_valid = 1'b0; if1.mem_we = '0; if1.mem_addr = '0; if1.mem_data = '0;
        settle(3);
        reset = 1'b0;
        @(negedge clk);

        check("rst_ready0", {31'd0, if0.mem_ready}, 32'd1);
        check("rst_resp_valid0", {31'd0, if0.mem_resp_valid}, 32'd0);
        check("rst_resp_data0", if0.mem_resp_data, 32'd0);
        check("rst_ready1", {31'd0, if1.mem_ready}, 32'd1);
        check("rst_resp_data1", if1.mem_resp_data, 32'd0);

        // Full write with ready timing, then readback.
        req(0, 8'h10, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF, acc);
        idle_all();
        for (int k = 1; k <= 4; k++) begin
            check("busy_ready_low", {31'd0, if0.mem_ready}, 32'd0);
            @(negedge clk);
        end
        check("ready_after_resp", {31'd0, if0.mem_ready}, 32'd1);
        check("ready_cycle", 32'(cyc), 32'(acc + 5));
        check("resp_data_hold", if0.mem_resp_data, 32'hDEADBEEF);
        req(0, 8'h10, 4'b0000, 32'h0, 32'hDEADBEEF, acc);
        idle_all();
        settle(5);

        // Byte-masked write and readback.
        req(0, 8'h10, 4'b0010, 32'h0000AB00, 32'hDEADABEF, acc);
        idle_all();
        settle(5);
        req(0, 8'h10, 4'b0000, 32'hFFFFFFFF, 32'hDEADABEF, acc);
        idle_all();
        settle(5);

        // Back-to-back reads with mem_valid held high.
        req(0, 8'h11, 4'b1111, 32'h12345678, 32'h12345678, acc);
        idle_all();
        settle(5);
        req(0, 8'h10, 4'b0000, 32'h0, 32'hDEADABEF, acc);
        req(0, 8'h11, 4'b0000, 32'h0, 32'h12345678, acc2);
        idle_all();
        check("b2b_accept_gap", 32'(acc2 - acc), 32'd5);
        settle(5);

        // Request while busy is ignored.
        req(0, 8'h20, 4'b1111, 32'h11112222, 32'h11112222, acc);
        idle_all();
        settle(5);
        req(0, 8'h10, 4'b0000, 32'h0, 32'hDEADABEF, acc);
        idle_all();
        @(negedge clk);
        if0.mem_valid = 1'b1; if0.mem_addr = 8'h20; if0.mem_we = 4'b1111; if0.mem_data = 32'h99999999;
        @(negedge clk);
        idle_all();
        settle(4);
        req(0, 8'h20, 4'b0000, 32'h0, 32'h11112222, acc);
        idle_all();
        settle(5);

        // Reset mid-operation: write persists, response is dropped.
        req(0, 8'h30, 4'b1111, 32'hCAFEF00D, 32'hCAFEF00D, acc);
        idle_all();
        @(negedge clk);
        reset = 1'b1;
        void'(q0.pop_back());
        @(negedge clk);
        reset = 1'b0;
        check("abort_no_resp_a", {31'd0, if0.mem_resp_valid}, 32'd0);
        @(negedge clk);
        check("abort_ready", {31'd0, if0.mem_ready}, 32'd1);
        check("abort_no_resp_b", {31'd0, if0.mem_resp_valid}, 32'd0);
        settle(3);
        req(0, 8'h30, 4'b0000, 32'h0, 32'hCAFEF00D, acc);
        idle_all();
        settle(5);

        // Request presented together with reset is not accepted.
        req(0, 8'h40, 4'b1111, 32'h0BADF00D, 32'h0BADF00D, acc);
        idle_all();
        settle(5);
        reset = 1'b1;
        if0.mem_valid = 1'b1; if0.mem_addr = 8'h40; if0.mem_we = 4'b1111; if0.mem_data = 32'h77777777;
        @(negedge clk);
        reset = 1'b0;
        idle_all();
        settle(5);
        req(0, 8'h40, 4'b0000, 32'h0, 32'h0BADF00D, acc);
        idle_all();
        settle(5);

        // LATENCY=1, DEPTH=16: aliasing and ready timing.
        req(1, 8'h03, 4'b1111, 32'h55AA55AA, 32'h55AA55AA, acc);
        if1.mem_valid = 1'b0;
        @(negedge clk);
        req(1, 8'h13, 4'b0000, 32'h0, 32'h55AA55AA, acc);
        if1.mem_valid = 1'b0;
        check("lat1_ready_low", {31'd0, if1.mem_ready}, 32'd0);
        @(negedge clk);
        check("lat1_ready_high", {31'd0, if1.mem_ready}, 32'd1);
        check("lat1_ready_cycle", 32'(cyc), 32'(acc + 2));
        settle(3);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
